// File: rtl/fib_index_finder.sv
// Classifies a value as Fibonacci or not by regenerating F(k) until it reaches or passes it.
// Optional FIB_INDEX_STATS_EN adds saturating query/hit/overflow counters.
module fib_index_finder #(
    parameter int W     = 8,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_is_fib,
    output logic [IDX_W-1:0] out_index,
    output logic             out_ovf
`ifdef FIB_INDEX_STATS_EN
    ,
    output logic [15:0]      stat_queries,
    output logic [15:0]      stat_hits,
    output logic [15:0]      stat_ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_value;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [IDX_W-1:0] r_k;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_is_fib;
    logic [IDX_W-1:0] r_index;
    logic             r_ovf;

    logic [W:0]       w_sum;
    logic             w_accept;
    logic             w_pop;

    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
    assign w_accept = in_valid && r_in_ready;
    assign w_pop    = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_value     <= '0;
            r_a         <= '0;
            r_b         <= W'(1);
            r_k         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_is_fib    <= 1'b0;
            r_index     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_value    <= in_value;
                        r_a        <= '0;
                        r_b        <= W'(1);
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (r_a == r_value) begin
                        r_is_fib    <= 1'b1;
                        r_index     <= r_k;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_a > r_value) begin
                        r_is_fib    <= 1'b0;
                        r_index     <= r_k;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_sum[W] && (r_b < r_value)) begin
                        // b is the last representable term below value; F(k+2) cannot fit.
                        r_is_fib    <= 1'b0;
                        r_index     <= r_k + IDX_W'(2);
                        r_ovf       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_a <= r_b;
                        r_b <= w_sum[W-1:0];
                        r_k <= r_k + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (w_pop) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_is_fib = r_is_fib;
    assign out_index  = r_index;
    assign out_ovf    = r_ovf;

`ifdef FIB_INDEX_STATS_EN
    logic [15:0] r_stat_queries;
    logic [15:0] r_stat_hits;
    logic [15:0] r_stat_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_queries <= '0;
            r_stat_hits    <= '0;
            r_stat_ovf     <= '0;
        end else begin
            if (w_accept && (r_stat_queries != 16'hFFFF)) begin
                r_stat_queries <= r_stat_queries + 16'd1;
            end
            if (w_pop && r_is_fib && (r_stat_hits != 16'hFFFF)) begin
                r_stat_hits <= r_stat_hits + 16'd1;
            end
            if (w_pop && r_ovf && (r_stat_ovf != 16'hFFFF)) begin
                r_stat_ovf <= r_stat_ovf + 16'd1;
            end
        end
    end

    assign stat_queries = r_stat_queries;
    assign stat_hits    = r_stat_hits;
    assign stat_ovf     = r_stat_ovf;
`endif

endmodule

// File: tb/tb_fib_index_finder.sv
// Directed self-checking bench for fib_index_finder (W=8, IDX_W=8).
module tb_fib_index_finder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_value;
    logic       out_valid;
    logic       out_ready;
    logic       out_is_fib;
    logic [7:0] out_index;
    logic       out_ovf;
`ifdef FIB_INDEX_STATS_EN
    logic [15:0] stat_queries;
    logic [15:0] stat_hits;
    logic [15:0] stat_ovf;
`endif

    int checks = 0;
    int errors = 0;

    fib_index_finder #(.W(8), .IDX_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_is_fib (out_is_fib),
        .out_index  (out_index),
        .out_ovf    (out_ovf)
`ifdef FIB_INDEX_STATS_EN
        ,
        .stat_queries (stat_queries),
        .stat_hits    (stat_hits),
        .stat_ovf     (stat_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch a query and count rising edges until out_valid; out_ready stays low.
    task automatic run_query(input logic [7:0] v, input logic hold_valid, output int lat);
        lat = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk);
        #1;
        in_valid = hold_valid;
        in_value = 8'd5;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout value=%0d out_valid=%0b want 1", v, out_valid);
        end
    endtask

    task automatic pop;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_value = 8'd0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
        checks++; if (out_is_fib !== 1'b0) begin errors++; $display("FAIL rst_is_fib got %0b want 0", out_is_fib); end
        checks++; if (out_index !== 8'd0) begin errors++; $display("FAIL rst_index got %0d want 0", out_index); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0b want 0", out_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero;
        int lat;
        run_query(8'd0, 1'b0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got %0d want 1", lat); end
        checks++; if (out_is_fib !== 1'b1) begin errors++; $display("FAIL zero_is_fib got %0b want 1", out_is_fib); end
        checks++; if (out_index !== 8'd0) begin errors++; $display("FAIL zero_index got %0d want 0", out_index); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL zero_ovf got %0b want 0", out_ovf); end
        pop();
    endtask

    task automatic test_thirteen;
        int lat;
        run_query(8'd13, 1'b0, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL q13_latency got %0d want 8", lat); end
        checks++; if (out_is_fib !== 1'b1) begin errors++; $display("FAIL q13_is_fib got %0b want 1", out_is_fib); end
        checks++; if (out_index !== 8'd7) begin errors++; $display("FAIL q13_index got %0d want 7", out_index); end
        pop();
    endtask

    task automatic test_one_and_four;
        int lat;
        run_query(8'd1, 1'b0, lat);
        checks++; if (out_is_fib !== 1'b1) begin errors++; $display("FAIL q1_is_fib got %0b want 1", out_is_fib); end
        checks++; if (out_index !== 8'd1) begin errors++; $display("FAIL q1_index got %0d want 1", out_index); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL q1_latency got %0d want 2", lat); end
        pop();
        run_query(8'd4, 1'b0, lat);
        checks++; if (out_is_fib !== 1'b0) begin errors++; $display("FAIL q4_is_fib got %0b want 0", out_is_fib); end
        checks++; if (out_index !== 8'd5) begin errors++; $display("FAIL q4_index got %0d want 5", out_index); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL q4_ovf got %0b want 0", out_ovf); end
        pop();
    endtask

    task automatic test_overflow;
        int lat;
        run_query(8'd255, 1'b0, lat);
        checks++; if (out_is_fib !== 1'b0) begin errors++; $display("FAIL q255_is_fib got %0b want 0", out_is_fib); end
        checks++; if (out_index !== 8'd14) begin errors++; $display("FAIL q255_index got %0d want 14", out_index); end
        checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL q255_ovf got %0b want 1", out_ovf); end
        checks++; if (lat !== 13) begin errors++; $display("FAIL q255_latency got %0d want 13", lat); end
        pop();
        run_query(8'd233, 1'b0, lat);
        checks++; if (out_is_fib !== 1'b1) begin errors++; $display("FAIL q233_is_fib got %0b want 1", out_is_fib); end
        checks++; if (out_index !== 8'd13) begin errors++; $display("FAIL q233_index got %0d want 13", out_index); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL q233_ovf got %0b want 0", out_ovf); end
        checks++; if (lat !== 14) begin errors++; $display("FAIL q233_latency got %0d want 14", lat); end
        pop();
    endtask

    task automatic test_backpressure;
        int lat;
        run_query(8'd21, 1'b1, lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL q21_latency got %0d want 9", lat); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc %0d got %0b want 1", c, out_valid); end
            checks++; if (out_index !== 8'd8) begin errors++; $display("FAIL hold_index cyc %0d got %0d want 8", c, out_index); end
            checks++; if (out_is_fib !== 1'b1) begin errors++; $display("FAIL hold_is_fib cyc %0d got %0b want 1", c, out_is_fib); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc %0d got %0b want 0", c, in_ready); end
        end
        pop();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_out_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pop_in_ready got %0b want 1", in_ready); end
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_reset_mid;
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 8'd144;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %0b want 0", out_valid); end
        checks++; if (out_index !== 8'd0) begin errors++; $display("FAIL midrst_index got %0d want 0", out_index); end
`ifdef FIB_INDEX_STATS_EN
        checks++; if (stat_queries !== 16'd0) begin errors++; $display("FAIL midrst_stat_q got %0d want 0", stat_queries); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL aborted_no_result got %0b want 0", out_valid); end
        run_query(8'd8, 1'b0, lat);
        checks++; if (out_index !== 8'd6) begin errors++; $display("FAIL q8_index got %0d want 6", out_index); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL q8_latency got %0d want 7", lat); end
        checks++; if (out_is_fib !== 1'b1) begin errors++; $display("FAIL q8_is_fib got %0b want 1", out_is_fib); end
        pop();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_thirteen();
        test_one_and_four();
        test_overflow();
        test_backpressure();
`ifdef FIB_INDEX_STATS_EN
        checks++; if (stat_queries !== 16'd7) begin errors++; $display("FAIL stat_queries got %0d want 7", stat_queries); end
        checks++; if (stat_hits !== 16'd5) begin errors++; $display("FAIL stat_hits got %0d want 5", stat_hits); end
        checks++; if (stat_ovf !== 16'd1) begin errors++; $display("FAIL stat_ovf got %0d want 1", stat_ovf); end
`endif
        test_reset_mid();
`ifdef FIB_INDEX_STATS_EN
        checks++; if (stat_queries !== 16'd1) begin errors++; $display("FAIL stat_queries_post got %0d want 1", stat_queries); end
        checks++; if (stat_hits !== 16'd1) begin errors++; $display("FAIL stat_hits_post got %0d want 1", stat_hits); end
        checks++; if (stat_ovf !== 16'd0) begin errors++; $display("FAIL stat_ovf_post got %0d want 0", stat_ovf); end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
